// File: rtl/croc_pkg.sv
// croc_pkg: shared encodings and helpers for the croc lane array.
//   MODE_WRAP / MODE_BOUNCE : per-lane motion mode encodings (mode_cfg bit)
//   DIR_DOWN / DIR_UP       : croc_dir encodings
//   RAMP_PERIOD / RAMP_MAX  : speed-ramp cadence (ticks) and bonus ceiling,
//                             used only when CROC_SPEED_RAMP_EN is defined
package croc_pkg;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int RAMP_PERIOD = 16;
    localparam int RAMP_MAX    = 3;

    // Left-edge X coordinate of lane idx.
    function automatic int lane_x(input int idx, input int x0, input int pitch);
        return x0 + idx * pitch;
    endfunction

endpackage

// File: rtl/croc_lane.sv
// croc_lane: one croc lane -- y/dir state, wrap/bounce next-state logic and
// the frog-vs-croc box overlap compare (combinational, on the current y).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_load            reload y from i_default_y, dir to down
//   i_step            apply one movement step this cycle
//   i_default_y       start Y for reload
//   i_speed           effective speed (pixels per step)
//   i_mode            MODE_WRAP / MODE_BOUNCE
//   i_frog_x/i_frog_y frog box top-left corner
//   o_y, o_dir        current croc top edge and direction
//   o_overlap         frog box overlaps this croc box
module croc_lane
    import croc_pkg::*;
#(
    parameter int POS_W  = 10,
    parameter int SPD_W  = 3,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 479,
    parameter int LX     = 300,
    parameter int CROC_W = 40,
    parameter int CROC_H = 40,
    parameter int FROG_W = 20,
    parameter int FROG_H = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [POS_W-1:0] i_default_y,
    input  logic [SPD_W-1:0] i_speed,
    input  logic             i_mode,
    input  logic [POS_W-1:0] i_frog_x,
    input  logic [POS_W-1:0] i_frog_y,
    output logic [POS_W-1:0] o_y,
    output logic             o_dir,
    output logic             o_overlap
);

    localparam int SW = POS_W + 1;  // movement sums
    localparam int CW = POS_W + 2;  // overlap compares, no overflow at X/Y edges

    logic [POS_W-1:0] r_y, w_y_nxt;
    logic             r_dir, w_dir_nxt;
    logic [SW-1:0]    w_s, w_sum, w_wrap;

    assign w_s   = SW'(i_speed);
    assign w_sum = SW'(r_y) + w_s;
    // Only used when w_sum > Y_MAX: Y_MIN + (sum - Y_MAX - 1)
    assign w_wrap = w_sum - SW'(Y_MAX + 1 - Y_MIN);

    always_comb begin
        w_y_nxt   = r_y;
        w_dir_nxt = r_dir;
        if (w_s != '0) begin
            if (i_mode == MODE_WRAP) begin
                w_dir_nxt = DIR_DOWN;
                w_y_nxt   = (w_sum > SW'(Y_MAX)) ? w_wrap[POS_W-1:0] : w_sum[POS_W-1:0];
            end else if (r_dir == DIR_DOWN) begin
                if (w_sum >= SW'(Y_MAX)) begin
                    w_y_nxt   = POS_W'(Y_MAX);
                    w_dir_nxt = DIR_UP;
                end else begin
                    w_y_nxt = w_sum[POS_W-1:0];
                end
            end else begin
                if (SW'(r_y) <= SW'(Y_MIN) + w_s) begin
                    w_y_nxt   = POS_W'(Y_MIN);
                    w_dir_nxt = DIR_DOWN;
                end else begin
                    w_y_nxt = r_y - w_s[POS_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= POS_W'(Y_MIN);
            r_dir <= DIR_DOWN;
        end else if (i_load) begin
            r_y   <= i_default_y;
            r_dir <= DIR_DOWN;
        end else if (i_step) begin
            r_y   <= w_y_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    logic [CW-1:0] w_fx, w_fy, w_cy;
    assign w_fx = CW'(i_frog_x);
    assign w_fy = CW'(i_frog_y);
    assign w_cy = CW'(r_y);

    assign o_overlap = (w_fx < CW'(LX + CROC_W)) && (CW'(LX) < w_fx + CW'(FROG_W)) &&
                       (w_fy < w_cy + CW'(CROC_H)) && (w_cy < w_fy + CW'(FROG_H));

    assign o_y   = r_y;
    assign o_dir = r_dir;

endmodule

// File: rtl/croc_lane_array.sv
// croc_lane_array: NUM_LANES croc lanes stepping on a shared frame tick, with
// sticky frog-vs-croc collision recording.
// Optional feature: define CROC_SPEED_RAMP_EN to add a saturating speed bonus
// (+1 every RAMP_PERIOD ticks, up to RAMP_MAX) to every moving lane.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            run (counter advances, collisions checked) / pause
//   load              reload start positions; clears counter, tick and hits
//   default_y         per-lane start Y, lane i at [i*POS_W +: POS_W]
//   speed_cfg         per-lane speed, lane i at [i*SPEED_W +: SPEED_W]
//   mode_cfg          per-lane mode (0 wrap, 1 bounce)
//   frog_x, frog_y    frog box top-left corner
//   croc_y, croc_dir  per-lane croc top edge and direction (0 down, 1 up)
//   tick              one-cycle movement-tick pulse
//   hit, hit_lane     sticky collision flag and per-lane collision record
module croc_lane_array
    import croc_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int POS_W      = 10,
    parameter int SPEED_W    = 3,
    parameter int TICK_DIV   = 262144,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int LANE_X0    = 300,
    parameter int LANE_PITCH = 150,
    parameter int CROC_W     = 40,
    parameter int CROC_H     = 40,
    parameter int FROG_W     = 20,
    parameter int FROG_H     = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         load,
    input  logic [NUM_LANES*POS_W-1:0]   default_y,
    input  logic [NUM_LANES*SPEED_W-1:0] speed_cfg,
    input  logic [NUM_LANES-1:0]         mode_cfg,
    input  logic [POS_W-1:0]             frog_x,
    input  logic [POS_W-1:0]             frog_y,
    output logic [NUM_LANES*POS_W-1:0]   croc_y,
    output logic [NUM_LANES-1:0]         croc_dir,
    output logic                         tick,
    output logic                         hit,
    output logic [NUM_LANES-1:0]         hit_lane
);

    localparam int CNT_W = $clog2(TICK_DIV);
`ifdef CROC_SPEED_RAMP_EN
    localparam int ESW = SPEED_W + 2;
`else
    localparam int ESW = SPEED_W;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_tick_now;  // counter at terminal while running
    logic             w_step;      // lanes move this edge (load suppresses)

    assign w_tick_now = enable && (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_step     = w_tick_now && !load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_now;
            if (w_tick_now)
                r_cnt <= '0;
            else if (enable)
                r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef CROC_SPEED_RAMP_EN
    logic [3:0] r_ramp_cnt;
    logic [1:0] r_bonus;

    // Bonus updates on the 16th tick, so it applies from the 17th tick on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp_cnt <= '0;
            r_bonus    <= '0;
        end else if (load) begin
            r_ramp_cnt <= '0;
            r_bonus    <= '0;
        end else if (w_step) begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
            if (r_ramp_cnt == 4'(RAMP_PERIOD - 1) && r_bonus != 2'(RAMP_MAX))
                r_bonus <= r_bonus + 1'b1;
        end
    end
`endif

    logic [NUM_LANES-1:0][ESW-1:0] w_eff_spd;
    logic [NUM_LANES-1:0]          w_overlap;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [SPEED_W-1:0] w_spd;
            assign w_spd = speed_cfg[gi*SPEED_W +: SPEED_W];
`ifdef CROC_SPEED_RAMP_EN
            // Stationary lanes stay stationary regardless of bonus.
            assign w_eff_spd[gi] = (w_spd == '0) ? '0 : ESW'(w_spd) + ESW'(r_bonus);
`else
            assign w_eff_spd[gi] = w_spd;
`endif
            croc_lane #(
                .POS_W (POS_W),
                .SPD_W (ESW),
                .Y_MIN (Y_MIN),
                .Y_MAX (Y_MAX),
                .LX    (lane_x(gi, LANE_X0, LANE_PITCH)),
                .CROC_W(CROC_W),
                .CROC_H(CROC_H),
                .FROG_W(FROG_W),
                .FROG_H(FROG_H)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_load     (load),
                .i_step     (w_step),
                .i_default_y(default_y[gi*POS_W +: POS_W]),
                .i_speed    (w_eff_spd[gi]),
                .i_mode     (mode_cfg[gi]),
                .i_frog_x   (frog_x),
                .i_frog_y   (frog_y),
                .o_y        (croc_y[gi*POS_W +: POS_W]),
                .o_dir      (croc_dir[gi]),
                .o_overlap  (w_overlap[gi])
            );
        end
    endgenerate

    logic                 r_hit;
    logic [NUM_LANES-1:0] r_hit_lane;

    // Overlap uses pre-update positions, so a tick-cycle hit sees the old y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit      <= 1'b0;
            r_hit_lane <= '0;
        end else if (load) begin
            r_hit      <= 1'b0;
            r_hit_lane <= '0;
        end else if (enable) begin
            r_hit      <= r_hit | (|w_overlap);
            r_hit_lane <= r_hit_lane | w_overlap;
        end
    end

    assign tick     = r_tick;
    assign hit      = r_hit;
    assign hit_lane = r_hit_lane;

endmodule

// File: tb/tb_croc_lane_array.sv
// tb_croc_lane_array: directed self-checking bench for croc_lane_array with
// TICK_DIV = 4. Inputs driven and outputs sampled on the falling clock edge.
module tb_croc_lane_array;

    localparam int NL = 3;
    localparam int PW = 10;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [NL*PW-1:0] default_y = '0;
    logic [NL*SW-1:0] speed_cfg = '0;
    logic [NL-1:0]    mode_cfg = '0;
    logic [PW-1:0]    frog_x = '0;
    logic [PW-1:0]    frog_y = '0;
    logic [NL*PW-1:0] croc_y;
    logic [NL-1:0]    croc_dir;
    logic             tick;
    logic             hit;
    logic [NL-1:0]    hit_lane;

    int vectors = 0;
    int errs    = 0;

    croc_lane_array #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .default_y(default_y), .speed_cfg(speed_cfg), .mode_cfg(mode_cfg),
        .frog_x(frog_x), .frog_y(frog_y),
        .croc_y(croc_y), .croc_dir(croc_dir), .tick(tick),
        .hit(hit), .hit_lane(hit_lane)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] ly(input int i);
        return croc_y[i*PW +: PW];
    endfunction

    task automatic do_load(input logic [PW-1:0] y2, input logic [PW-1:0] y1, input logic [PW-1:0] y0);
        default_y = {y2, y1, y0};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (tick === 1'b1) got = 1'b1;
        end
        if (!got) begin
            vectors++; errs++;
            $display("FAIL tick_timeout: no tick within 8 cycles");
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (croc_y !== '0 || croc_dir !== '0 || tick !== 1'b0 || hit !== 1'b0 || hit_lane !== '0) begin
            errs++;
            $display("FAIL reset_state: y=%h dir=%b tick=%b hit=%b hl=%b, want all zero",
                     croc_y, croc_dir, tick, hit, hit_lane);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_tick();
        enable = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            vectors++;
            if (tick !== (k % 4 == 0)) begin
                errs++;
                $display("FAIL tick_period k=%0d: tick=%b want %b", k, tick, (k % 4 == 0));
            end
        end
        vectors++;
        if (croc_y !== '0) begin
            errs++;
            $display("FAIL tick_still: croc_y=%h want 0", croc_y);
        end
        enable = 1'b0;  // counter now at 1
        repeat (6) @(negedge clk);
        vectors++;
        if (tick !== 1'b0) begin
            errs++;
            $display("FAIL pause_tick: tick=%b want 0", tick);
        end
        enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if (tick !== (k == 3)) begin
                errs++;
                $display("FAIL resume k=%0d: tick=%b want %b", k, tick, (k == 3));
            end
        end
    endtask

    task automatic test_wrap();
        frog_x = '0; frog_y = '0;
        speed_cfg = {3'd0, 3'd0, 3'd7};
        mode_cfg  = 3'b000;
        do_load(10'd0, 10'd0, 10'd470);
        vectors++;
        if (ly(0) !== 10'd470) begin
            errs++; $display("FAIL wrap_load: y0=%0d want 470", ly(0));
        end
        wait_tick();
        vectors++;
        if (ly(0) !== 10'd477 || croc_dir[0] !== 1'b0) begin
            errs++; $display("FAIL wrap_step: y0=%0d dir=%b want 477/0", ly(0), croc_dir[0]);
        end
        wait_tick();
        vectors++;
        if (ly(0) !== 10'd4 || croc_dir[0] !== 1'b0) begin
            errs++; $display("FAIL wrap_wrap: y0=%0d dir=%b want 4/0", ly(0), croc_dir[0]);
        end
    endtask

    task automatic test_bounce();
        speed_cfg = {3'd5, 3'd5, 3'd0};
        mode_cfg  = 3'b110;
        do_load(10'd474, 10'd475, 10'd200);
        wait_tick();
        vectors++;
        if (ly(1) !== 10'd479 || croc_dir[1] !== 1'b1) begin
            errs++; $display("FAIL bounce_top: y1=%0d dir=%b want 479/1", ly(1), croc_dir[1]);
        end
        vectors++;
        if (ly(2) !== 10'd479 || croc_dir[2] !== 1'b1) begin
            errs++; $display("FAIL bounce_top_eq: y2=%0d dir=%b want 479/1", ly(2), croc_dir[2]);
        end
        vectors++;
        if (ly(0) !== 10'd200) begin
            errs++; $display("FAIL speed0_hold: y0=%0d want 200", ly(0));
        end
        // lane 2 switches to wrap while moving up; lane 1 speeds up
        mode_cfg  = 3'b010;
        speed_cfg = {3'd5, 3'd7, 3'd0};
        wait_tick();
        vectors++;
        if (ly(2) !== 10'd4 || croc_dir[2] !== 1'b0) begin
            errs++; $display("FAIL wrap_forces_down: y2=%0d dir=%b want 4/0", ly(2), croc_dir[2]);
        end
        vectors++;
        if (ly(1) !== 10'd472 || croc_dir[1] !== 1'b1) begin
            errs++; $display("FAIL bounce_up: y1=%0d dir=%b want 472/1", ly(1), croc_dir[1]);
        end
        speed_cfg = {3'd0, 3'd7, 3'd0};
        for (int k = 0; k < 67; k++) wait_tick();
        vectors++;
        if (ly(1) !== 10'd3 || croc_dir[1] !== 1'b1 || ly(2) !== 10'd4) begin
            errs++; $display("FAIL bounce_near_min: y1=%0d dir=%b y2=%0d want 3/1/4", ly(1), croc_dir[1], ly(2));
        end
        speed_cfg = {3'd0, 3'd5, 3'd0};
        wait_tick();
        vectors++;
        if (ly(1) !== 10'd0 || croc_dir[1] !== 1'b0) begin
            errs++; $display("FAIL bounce_bottom: y1=%0d dir=%b want 0/0", ly(1), croc_dir[1]);
        end
        wait_tick();
        vectors++;
        if (ly(1) !== 10'd5 || croc_dir[1] !== 1'b0) begin
            errs++; $display("FAIL bounce_down_again: y1=%0d dir=%b want 5/0", ly(1), croc_dir[1]);
        end
    endtask

    task automatic test_collision();
        speed_cfg = '0;
        mode_cfg  = '0;
        frog_x = '0; frog_y = '0;
        do_load(10'd0, 10'd0, 10'd108);
        vectors++;
        if (hit !== 1'b0 || hit_lane !== 3'b000) begin
            errs++; $display("FAIL coll_clear: hit=%b hl=%b want 0/000", hit, hit_lane);
        end
        frog_x = 10'd340; frog_y = 10'd110;  // touches right edge only
        repeat (2) @(negedge clk);
        vectors++;
        if (hit !== 1'b0) begin
            errs++; $display("FAIL coll_x_edge: hit=%b want 0", hit);
        end
        frog_x = 10'd305; frog_y = 10'd148;  // touches bottom edge only
        repeat (2) @(negedge clk);
        vectors++;
        if (hit !== 1'b0) begin
            errs++; $display("FAIL coll_y_edge: hit=%b want 0", hit);
        end
        enable = 1'b0;
        frog_y = 10'd110;
        repeat (2) @(negedge clk);
        vectors++;
        if (hit !== 1'b0) begin
            errs++; $display("FAIL coll_paused: hit=%b want 0", hit);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (hit !== 1'b1 || hit_lane !== 3'b001) begin
            errs++; $display("FAIL coll_hit: hit=%b hl=%b want 1/001", hit, hit_lane);
        end
        frog_x = '0; frog_y = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (hit !== 1'b1 || hit_lane !== 3'b001) begin
            errs++; $display("FAIL coll_sticky: hit=%b hl=%b want 1/001", hit, hit_lane);
        end
        do_load(10'd70, 10'd60, 10'd50);
        vectors++;
        if (hit !== 1'b0 || hit_lane !== 3'b000 || croc_y !== {10'd70, 10'd60, 10'd50}) begin
            errs++; $display("FAIL coll_load: hit=%b hl=%b y=%h want 0/000/%h", hit, hit_lane,
                             croc_y, {10'd70, 10'd60, 10'd50});
        end
        frog_x = 10'd460; frog_y = 10'd50;
        @(negedge clk);
        vectors++;
        if (hit !== 1'b1 || hit_lane !== 3'b010) begin
            errs++; $display("FAIL coll_lane1: hit=%b hl=%b want 1/010", hit, hit_lane);
        end
        frog_x = '0; frog_y = '0;
    endtask

    task automatic test_load_tick();
        speed_cfg = {3'd0, 3'd0, 3'd3};
        mode_cfg  = '0;
        do_load(10'd0, 10'd0, 10'd10);
        repeat (3) @(negedge clk);  // counter now at terminal
        vectors++;
        if (ly(0) !== 10'd10 || tick !== 1'b0) begin
            errs++; $display("FAIL pre_load_tick: y0=%0d tick=%b want 10/0", ly(0), tick);
        end
        do_load(10'd0, 10'd0, 10'd100);
        vectors++;
        if (ly(0) !== 10'd100 || tick !== 1'b0) begin
            errs++; $display("FAIL load_beats_tick: y0=%0d tick=%b want 100/0", ly(0), tick);
        end
        wait_tick();
        vectors++;
        if (ly(0) !== 10'd103) begin
            errs++; $display("FAIL after_load_tick: y0=%0d want 103", ly(0));
        end
    endtask

    task automatic test_reset_mid();
        speed_cfg = '0;
        do_load(10'd0, 10'd0, 10'd108);
        frog_x = 10'd305; frog_y = 10'd110;
        wait_tick();
        vectors++;
        if (hit !== 1'b1 || tick !== 1'b1 || ly(0) !== 10'd108) begin
            errs++; $display("FAIL pre_reset: hit=%b tick=%b y0=%0d want 1/1/108", hit, tick, ly(0));
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (croc_y !== '0 || croc_dir !== '0 || tick !== 1'b0 || hit !== 1'b0 || hit_lane !== '0) begin
            errs++; $display("FAIL async_reset: y=%h dir=%b tick=%b hit=%b hl=%b want all zero",
                             croc_y, croc_dir, tick, hit, hit_lane);
        end
        enable = 1'b0;
        frog_x = '0; frog_y = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

`ifdef CROC_SPEED_RAMP_EN
    task automatic test_ramp();
        speed_cfg = {3'd0, 3'd0, 3'd1};
        mode_cfg  = '0;
        frog_x = '0; frog_y = '0;
        enable = 1'b1;
        do_load(10'd0, 10'd50, 10'd0);
        for (int k = 0; k < 16; k++) wait_tick();
        vectors++;
        if (ly(0) !== 10'd16) begin
            errs++; $display("FAIL ramp_16: y0=%0d want 16", ly(0));
        end
        wait_tick();
        vectors++;
        if (ly(0) !== 10'd18) begin
            errs++; $display("FAIL ramp_17: y0=%0d want 18", ly(0));
        end
        for (int k = 0; k < 31; k++) wait_tick();
        vectors++;
        if (ly(0) !== 10'd96) begin
            errs++; $display("FAIL ramp_48: y0=%0d want 96", ly(0));
        end
        wait_tick();
        wait_tick();
        vectors++;
        if (ly(0) !== 10'd104 || ly(1) !== 10'd50) begin
            errs++; $display("FAIL ramp_sat: y0=%0d y1=%0d want 104/50", ly(0), ly(1));
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CROC_SPEED_RAMP_EN
        test_ramp();
`else
        test_tick();
        test_wrap();
        test_bounce();
        test_collision();
        test_load_tick();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/croc_lane_array.md
Name: croc_lane_array

Overview:
- Parametrised successor to the per-lane croc mover: N obstacle lanes advance on a shared internal frame tick.
- Each lane has a per-lane speed, a wrap or bounce mode, and a reloadable start position.
- Registered frog-versus-croc collision detection is built in, with a sticky per-lane hit record.
- Sits between the game top level (frog position, debounced controls) and the VGA renderer, which consumes croc_y.

Parameters:
NUM_LANES, 3, number of croc lanes
POS_W, 10, coordinate width in bits
SPEED_W, 3, per-lane speed field width (pixels per tick)
TICK_DIV, 262144, clk cycles per movement tick (>=2)
Y_MIN, 0, top of travel range
Y_MAX, 479, bottom of travel range (croc top-edge coordinate)
LANE_X0, 300, X of lane 0 left edge
LANE_PITCH, 150, X spacing between lanes; lane i X = LANE_X0 + i*LANE_PITCH
CROC_W, 40, croc box width; CROC_H, 40, croc box height
FROG_W, 20, frog box width; FROG_H, 20, frog box height

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  1 = run (tick counter advances, collisions checked); 0 = pause
load  in  1  synchronous reload of start positions
default_y  in  NUM_LANES*POS_W  per-lane start Y, lane i at bits [i*POS_W +: POS_W]
speed_cfg  in  NUM_LANES*SPEED_W  per-lane speed
mode_cfg  in  NUM_LANES  per-lane mode: 0 = wrap, 1 = bounce
frog_x  in  POS_W  frog left edge
frog_y  in  POS_W  frog top edge
croc_y  out  NUM_LANES*POS_W  current croc top edges
croc_dir  out  NUM_LANES  0 = moving down, 1 = moving up
tick  out  1  one-cycle movement-tick pulse
hit  out  1  sticky collision flag
hit_lane  out  NUM_LANES  sticky one-hot-OR of lanes that collided

Behaviour:
- Reset, asynchronous and applied immediately:
  - croc_y = Y_MIN, croc_dir = 0, hit = 0, hit_lane = 0, tick = 0, tick counter = 0.
  - Mid-operation reset discards all state.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable = 1, holds while enable = 0.
  - At TICK_DIV-1 it wraps to 0 and tick is registered high for exactly one cycle.
  - Period is TICK_DIV cycles of enabled time.
- load has priority over everything except rst. In the cycle load = 1:
  - croc_y <= default_y, croc_dir <= 0.
  - tick counter <= 0, tick <= 0.
  - hit <= 0, hit_lane <= 0.
- Lane update on a tick cycle (croc_y changes on the same clock edge tick rises; latency 1 cycle after counter terminal). With s = speed, sums computed at POS_W+1 bits:
  - s = 0: lane holds position and direction.
  - Wrap mode: always moves down; croc_dir forced to 0 on that tick. If y+s > Y_MAX, y <= Y_MIN + (y+s-Y_MAX-1); else y <= y+s.
  - Bounce, down: if y+s >= Y_MAX, y <= Y_MAX and dir <= 1; else y <= y+s.
  - Bounce, up: if y <= Y_MIN+s, y <= Y_MIN and dir <= 0; else y <= y-s.
  - mode_cfg and speed_cfg are sampled only on tick cycles; changes between ticks take effect at the next tick.
- Collision, every cycle with enable = 1 and load = 0:
  - Lane i overlaps when frog_x < LX+CROC_W, LX < frog_x+FROG_W, frog_y < y+CROC_H and y < frog_y+FROG_H, using pre-update croc_y.
  - hit_lane[i] |= overlap_i and hit |= any overlap, registered, visible 1 cycle later.
  - Sticky until load or rst. No checking while paused.
- Simultaneous events: load and tick together → load wins. Overlap in a tick cycle uses the old position.

Optional Feature:
- Macro CROC_SPEED_RAMP_EN.
- Defined:
  - Internal 2-bit bonus counter, saturating at 3, increments once every 16 ticks.
  - Effective speed = speed_cfg + bonus, computed at SPEED_W+2 bits; lanes with speed_cfg = 0 stay stationary.
  - Bonus clears on load or rst.
- Undefined: effective speed = speed_cfg; no bonus logic is present.

Decomposition:
- Package croc_pkg holds:
  - mode encodings MODE_WRAP = 0, MODE_BOUNCE = 1;
  - direction encodings DIR_DOWN = 0, DIR_UP = 1;
  - RAMP_PERIOD = 16 and RAMP_MAX = 3.
- Sub-module croc_lane holds one lane's y/dir register, the wrap/bounce next-state logic and the overlap compare. It is instantiated NUM_LANES times in a generate loop; the top holds the tick counter, ramp logic and hit aggregation.

Test Plan:
- Set TICK_DIV = 4, enable = 1, rst pulse → tick high every 4th cycle, all croc_y = 0; enable = 0 mid-count → counter and tick frozen; re-enable resumes the count.
- Wrap lane, y = 470, speed 7 → 477; next tick → Y_MIN + (484-480) = 4, croc_dir = 0.
- Bounce lane, y = 475, speed 5 → y = 479, dir = 1; y = 3, speed 5, dir = 1 → y = 0, dir = 0; speed 0 → y unchanged.
- Frog at (305, 110), lane 0 y = 108 → hit = 1 and hit_lane = 3'b001 one cycle later; frog moved away → hit stays 1; load → hit = 0, croc_y = default_y.
- load asserted in the same cycle as tick → positions equal default_y, no move applied; rst asserted mid-tick-period → outputs clear immediately, asynchronously.
- With CROC_SPEED_RAMP_EN defined, speed 1 → per-tick step becomes 2 after 16 ticks, saturates at 4 after 48 ticks; speed-0 lane never moves.
